// File: rtl/vid_pkg.sv
// Shared types and constants for the video pixel-fetch slice: fetch state
// encoding, RGB widths and the colour-bar palette.
package vid_pkg;

  localparam int RGB565_W = 16;
  localparam int RGB888_W = 24;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_STREAM = 2'd2
  } fetch_state_e;

  localparam logic [RGB888_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB888_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB888_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB888_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB888_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB888_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB888_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB888_W-1:0] BAR_BLACK   = 24'h000000;

  function automatic logic [RGB888_W-1:0] bar_colour(input logic [2:0] idx);
    logic [RGB888_W-1:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb565_to_888.sv
// Combinational RGB565 -> RGB888 expansion; low bits replicate the MSBs so
// full-scale inputs map to full-scale outputs.
module rgb565_to_888
  import vid_pkg::*;
(
  input  logic [RGB565_W-1:0] i_rgb565,
  output logic [RGB888_W-1:0] o_rgb888
);

  logic [4:0] w_r5;
  logic [5:0] w_g6;
  logic [4:0] w_b5;

  assign w_r5 = i_rgb565[15:11];
  assign w_g6 = i_rgb565[10:5];
  assign w_b5 = i_rgb565[4:0];

  assign o_rgb888 = {w_r5, w_r5[4:2], w_g6, w_g6[5:4], w_b5, w_b5[4:2]};

endmodule

// File: rtl/vid_pixel_fetch.sv
// Pixel-fetch stage: frame-locks the RGB565 read stream to the timing
// generator and emits registered RGB888 video. Optional colour bars: VID_FETCH_BAR_EN.
module vid_pixel_fetch
  import vid_pkg::*;
#(
  parameter logic                VS_POL   = 1'b1,
  parameter logic [RGB888_W-1:0] FILL_RGB = 24'h000000,
  parameter int                  CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                t_hs,
  input  logic                t_vs,
  input  logic                t_de,
  input  logic [9:0]          t_x,
  input  logic [9:0]          t_y,
  input  logic [RGB565_W-1:0] pix_data,
  input  logic                pix_valid,
  input  logic                pix_sof,
`ifdef VID_FETCH_BAR_EN
  input  logic                bar_en,
`endif
  output logic                pix_ready,
  output logic                vid_hs,
  output logic                vid_vs,
  output logic                vid_de,
  output logic [RGB888_W-1:0] vid_rgb,
  output logic [CNT_W-1:0]    underflow_cnt,
  output logic                sync_lost
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic                r_first;
  logic                w_first_nxt;
  logic                r_vs_prev;
  logic                w_frame_start;
  logic                w_ready;
  logic                w_show;
  logic                w_starve;
  logic                w_sync_lost;
  logic [RGB888_W-1:0] w_pix888;
  logic [RGB888_W-1:0] w_rgb_nxt;
  logic                w_unused;

  logic [RGB888_W-1:0] r_rgb;
  logic [CNT_W-1:0]    r_underflow_cnt;
  logic                r_hs;
  logic                r_vs;
  logic                r_de;
  logic                r_sync_lost;

`ifdef VID_FETCH_BAR_EN
  assign w_unused = ^{t_y, t_x[6:0]};
`else
  assign w_unused = ^{t_y, t_x};
`endif

  assign w_frame_start = (t_vs == VS_POL) && (r_vs_prev != VS_POL);

  rgb565_to_888 u_expand (
    .i_rgb565 (pix_data),
    .o_rgb888 (w_pix888)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_first_nxt = r_first;
    w_ready     = 1'b0;
    w_show      = 1'b0;
    w_starve    = 1'b0;
    w_sync_lost = 1'b0;
    case (r_state)
      ST_HUNT: begin
        // Drain stale pixels until a frame head sits at the front.
        w_ready = pix_valid && !pix_sof;
        if (pix_valid && pix_sof) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_HUNT;
        end
      end
      ST_ARMED: begin
        if (w_frame_start) begin
          w_state_nxt = ST_STREAM;
          w_first_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_STREAM: begin
        w_ready     = t_de && pix_valid && !(pix_sof && !r_first);
        w_show      = w_ready;
        w_starve    = t_de && !pix_valid;
        w_sync_lost = t_de && pix_valid && pix_sof && !r_first;
        if (w_ready) begin
          w_first_nxt = 1'b0;
        end else begin
          w_first_nxt = r_first;
        end
        // A new frame start overrides a same-cycle sync loss.
        if (w_frame_start) begin
          w_state_nxt = ST_HUNT;
        end else if (w_sync_lost) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_first_nxt = 1'b1;
      end
    endcase
  end

  assign pix_ready = w_ready && !rst;

  always_comb begin
    w_rgb_nxt = 24'h000000;
    if (t_de) begin
`ifdef VID_FETCH_BAR_EN
      if (bar_en) begin
        w_rgb_nxt = bar_colour(t_x[9:7]);
      end else if (w_show) begin
        w_rgb_nxt = w_pix888;
      end else begin
        w_rgb_nxt = FILL_RGB;
      end
`else
      if (w_show) begin
        w_rgb_nxt = w_pix888;
      end else begin
        w_rgb_nxt = FILL_RGB;
      end
`endif
    end else begin
      w_rgb_nxt = 24'h000000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_HUNT;
      r_first   <= 1'b1;
      r_vs_prev <= ~VS_POL;
    end else begin
      r_state   <= w_state_nxt;
      r_first   <= w_first_nxt;
      r_vs_prev <= t_vs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs            <= 1'b0;
      r_vs            <= 1'b0;
      r_de            <= 1'b0;
      r_rgb           <= 24'h000000;
      r_sync_lost     <= 1'b0;
      r_underflow_cnt <= {CNT_W{1'b0}};
    end else begin
      r_hs        <= t_hs;
      r_vs        <= t_vs;
      r_de        <= t_de;
      r_rgb       <= w_rgb_nxt;
      r_sync_lost <= w_sync_lost;
      if (w_starve && (r_underflow_cnt != {CNT_W{1'b1}})) begin
        r_underflow_cnt <= r_underflow_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_underflow_cnt <= r_underflow_cnt;
      end
    end
  end

  assign vid_hs        = r_hs;
  assign vid_vs        = r_vs;
  assign vid_de        = r_de;
  assign vid_rgb       = r_rgb;
  assign underflow_cnt = r_underflow_cnt;
  assign sync_lost     = r_sync_lost;

endmodule

// File: tb/tb_vid_pixel_fetch.sv
// Randomized bench for vid_pixel_fetch: small raster, a pixel-stream queue
// with junk/short/long frames, and a frame-lock reference model.
module tb_vid_pixel_fetch;

  localparam logic [23:0] FILL  = 24'h5A3C96;
  localparam int          CW    = 4;
  localparam int          H_TOT = 24;
  localparam int          H_ACT = 16;
  localparam int          V_TOT = 10;
  localparam int          V_ACT = 6;
  localparam int          N_CYC = 9000;
  localparam int          NPIX  = H_ACT * V_ACT;

  localparam int P_HUNT   = 0;
  localparam int P_ARMED  = 1;
  localparam int P_STREAM = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          t_hs, t_vs, t_de;
  logic [9:0]    t_x, t_y;
  logic [15:0]   pix_data;
  logic          pix_valid, pix_sof;
  logic          pix_ready;
  logic          vid_hs, vid_vs, vid_de;
  logic [23:0]   vid_rgb;
  logic [CW-1:0] underflow_cnt;
  logic          sync_lost;
`ifdef VID_FETCH_BAR_EN
  logic          bar_en = 1'b0;
`endif

  vid_pixel_fetch #(
    .VS_POL   (1'b1),
    .FILL_RGB (FILL),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .t_hs          (t_hs),
    .t_vs          (t_vs),
    .t_de          (t_de),
    .t_x           (t_x),
    .t_y           (t_y),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
`ifdef VID_FETCH_BAR_EN
    .bar_en        (bar_en),
`endif
    .pix_ready     (pix_ready),
    .vid_hs        (vid_hs),
    .vid_vs        (vid_vs),
    .vid_de        (vid_de),
    .vid_rgb       (vid_rgb),
    .underflow_cnt (underflow_cnt),
    .sync_lost     (sync_lost)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream source: bit 16 = start-of-frame, bits 15:0 = RGB565.
  logic [16:0] src_q[$];

  task automatic push_frame(input bit fixed_head, input logic [15:0] head);
    int n;
    int junk;
    n = NPIX;
    junk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    case ($urandom_range(0, 5))
      0:       n = NPIX - $urandom_range(1, 4);
      1:       n = NPIX + $urandom_range(1, 4);
      default: n = NPIX;
    endcase
    for (int j = 0; j < junk; j++) src_q.push_back({1'b0, 16'($urandom)});
    for (int j = 0; j < n; j++) begin
      if (j == 0) src_q.push_back({1'b1, fixed_head ? head : 16'($urandom)});
      else        src_q.push_back({1'b0, 16'($urandom)});
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] d);
    int r, g, b;
    r = int'(d[15:11]);
    g = int'(d[10:5]);
    b = int'(d[4:0]);
    return 24'(((r * 8 + r / 4) << 16) | ((g * 4 + g / 16) << 8) | (b * 8 + b / 4));
  endfunction

  // Reference-model state and expected outputs.
  int          m_phase;
  bit          m_first;
  bit          m_vs_prev;
  int          m_cnt;
  bit          m_ready;
  logic        e_hs, e_vs, e_de, e_sl;
  logic [23:0] e_rgb;
  bit          want_first = 1'b0;
  bit          first_done = 1'b0;

  task automatic model_step();
    bit fs, show, starve, lost;
    int nphase;
    if (rst) begin
      m_ready = 1'b0;
      e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_sl = 1'b0; e_rgb = 24'h0;
      m_phase = P_HUNT; m_first = 1'b1; m_vs_prev = 1'b0; m_cnt = 0;
    end else begin
      fs = t_vs && !m_vs_prev;
      m_vs_prev = t_vs;
      show = 1'b0; starve = 1'b0; lost = 1'b0;
      nphase = m_phase;
      m_ready = 1'b0;
      if (m_phase == P_HUNT) begin
        m_ready = pix_valid && !pix_sof;
        if (pix_valid && pix_sof) nphase = P_ARMED;
      end else if (m_phase == P_ARMED) begin
        if (fs) begin nphase = P_STREAM; m_first = 1'b1; end
      end else begin
        lost    = t_de && pix_valid && pix_sof && !m_first;
        m_ready = t_de && pix_valid && !lost;
        show    = m_ready;
        starve  = t_de && !pix_valid;
        if (m_ready) m_first = 1'b0;
        if (fs)        nphase = P_HUNT;
        else if (lost) nphase = P_ARMED;
      end
      if (starve && m_cnt < (1 << CW) - 1) m_cnt++;
      e_hs = t_hs; e_vs = t_vs; e_de = t_de; e_sl = lost;
      e_rgb = !t_de ? 24'h0 : (show ? expand(pix_data) : FILL);
      if (show && !first_done) begin want_first = 1'b1; first_done = 1'b1; end
      m_phase = nphase;
    end
  endtask

  initial begin
    int  hcnt, vcnt;
    bit  have_exp, starve_win;
    hcnt = 0; vcnt = 0; have_exp = 1'b0;
    rst = 1'b1; t_hs = 1'b0; t_vs = 1'b0; t_de = 1'b0; t_x = 10'd0; t_y = 10'd0;
    pix_data = 16'h0; pix_valid = 1'b0; pix_sof = 1'b0;
    // Four stale pixels ahead of the first frame head.
    for (int j = 0; j < 4; j++) src_q.push_back({1'b0, 16'($urandom)});
    src_q.push_back({1'b1, 16'h07E0});
    for (int j = 1; j < NPIX; j++) src_q.push_back({1'b0, 16'($urandom)});

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      if (have_exp) begin
        chk_eq("vid_hs", 32'(vid_hs), 32'(e_hs));
        chk_eq("vid_vs", 32'(vid_vs), 32'(e_vs));
        chk_eq("vid_de", 32'(vid_de), 32'(e_de));
        chk_eq("vid_rgb", 32'(vid_rgb), 32'(e_rgb));
        chk_eq("underflow_cnt", 32'(underflow_cnt), 32'(m_cnt));
        chk_eq("sync_lost", 32'(sync_lost), 32'(e_sl));
        if (want_first) begin
          chk_eq("first_px", 32'(vid_rgb), 32'h0000FF00);
          want_first = 1'b0;
        end
      end
      if (cyc == 3) begin
        chk_eq("rst_rgb", 32'(vid_rgb), 32'h0);
        chk_eq("rst_cnt", 32'(underflow_cnt), 32'h0);
        chk_eq("rst_de", 32'(vid_de), 32'h0);
      end

      rst  = (cyc < 3) || (cyc % 1700 == 900);
      t_de = (hcnt < H_ACT) && (vcnt < V_ACT);
      t_hs = (hcnt >= 18) && (hcnt < 20);
      t_vs = (vcnt == 8);
      t_x  = 10'(hcnt * 19);
      t_y  = 10'(vcnt);
      hcnt++;
      if (hcnt == H_TOT) begin
        hcnt = 0;
        vcnt = (vcnt + 1) % V_TOT;
      end

      while (src_q.size() < 150) push_frame(1'b0, 16'h0);
      starve_win = (cyc >= 8500) && (cyc < 8560);
      pix_valid  = !starve_win && (cyc < 300 || $urandom_range(0, 7) != 0);
      pix_data   = pix_valid ? src_q[0][15:0] : 16'($urandom);
      pix_sof    = pix_valid ? src_q[0][16] : 1'b0;

      #1;
      model_step();
      chk_eq("pix_ready", 32'(pix_ready), 32'(m_ready));
      if (m_ready) void'(src_q.pop_front());
      have_exp = 1'b1;
    end

    @(negedge clk);
    chk_eq("cnt_saturated", 32'(underflow_cnt), 32'h0000000F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
